// File: rtl/vic_irq_arbiter.sv
// Vectored interrupt arbiter: rising-edge sources latch into a pending register,
// the lowest enabled pending index is issued as a one-cycle o_IRQ with its vector address.
module vic_irq_arbiter #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_IRQ-1:0] i_src,
    input  logic [NUM_IRQ-1:0] i_en,
    input  logic               i_reti,
    input  logic               i_vec_we,
    input  logic [2:0]         i_vec_idx,
    input  logic [31:0]        i_vec_data,
    output logic               o_IRQ,
    output logic [31:0]        o_ISR_addr,
    output logic [2:0]         o_active_id,
    output logic               o_busy,
    output logic [NUM_IRQ-1:0] o_pending
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SERVICE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] src_q;
    logic               armed_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [31:0]        vec_q [NUM_IRQ];
    logic [31:0]        vec_d [NUM_IRQ];
    logic [31:0]        isr_addr_q, isr_addr_d;
    logic [2:0]         active_id_q, active_id_d;

    logic [NUM_IRQ-1:0] edges;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clear_mask;
    logic [2:0]         winner;
    logic               take;

    always_comb begin
        // armed_q masks the first sample after reset so lines already high do not fire
        edges    = i_src & ~src_q & {NUM_IRQ{armed_q}};
        eligible = pending_q & i_en;

        winner = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                winner = 3'(k);
            end
        end

        take = (|eligible) && ((state_q == IDLE) || ((state_q == SERVICE) && i_reti));

        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = ISSUE;
            ISSUE:   state_d = SERVICE;
            SERVICE: if (i_reti) state_d = take ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase

        clear_mask  = '0;
        isr_addr_d  = isr_addr_q;
        active_id_d = active_id_q;
        if (take) begin
            clear_mask[winner] = 1'b1;
            isr_addr_d         = vec_q[winner];
            active_id_d        = winner;
        end

        // a fresh edge on the winner re-arms it in the same cycle it is consumed
        pending_d = (pending_q & ~clear_mask) | edges;

        vec_d = vec_q;
        if (i_vec_we) begin
            vec_d[i_vec_idx] = i_vec_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            src_q       <= '0;
            armed_q     <= 1'b0;
            pending_q   <= '0;
            isr_addr_q  <= '0;
            active_id_q <= '0;
            for (int k = 0; k < NUM_IRQ; k++) begin
                vec_q[k] <= VEC_BASE + VEC_STRIDE * 32'(k);
            end
        end else begin
            state_q     <= state_d;
            src_q       <= i_src;
            armed_q     <= 1'b1;
            pending_q   <= pending_d;
            isr_addr_q  <= isr_addr_d;
            active_id_q <= active_id_d;
            vec_q       <= vec_d;
        end
    end

    assign o_IRQ       = (state_q == ISSUE);
    assign o_busy      = (state_q != IDLE);
    assign o_ISR_addr  = isr_addr_q;
    assign o_active_id = active_id_q;
    assign o_pending   = pending_q;

endmodule

// File: tb/tb_vic_irq_arbiter.sv
// Self-checking bench for vic_irq_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_vic_irq_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_src;
    logic [7:0]  i_en;
    logic        i_reti;
    logic        i_vec_we;
    logic [2:0]  i_vec_idx;
    logic [31:0] i_vec_data;
    logic        o_IRQ;
    logic [31:0] o_ISR_addr;
    logic [2:0]  o_active_id;
    logic        o_busy;
    logic [7:0]  o_pending;

    int assertCount = 0;
    int failCount   = 0;

    vic_irq_arbiter dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_src      (i_src),
        .i_en       (i_en),
        .i_reti     (i_reti),
        .i_vec_we   (i_vec_we),
        .i_vec_idx  (i_vec_idx),
        .i_vec_data (i_vec_data),
        .o_IRQ      (o_IRQ),
        .o_ISR_addr (o_ISR_addr),
        .o_active_id(o_active_id),
        .o_busy     (o_busy),
        .o_pending  (o_pending)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: phase is 0 idle, 1 issuing, 2 in service
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_SERVICE = 2;
    int          mPhase;
    bit [7:0]    mPrev;
    bit          mSeenClock;
    bit [7:0]    mPend;
    bit [31:0]   mVec [8];
    bit [31:0]   mAddr;
    int          mId;

    function automatic int lowestSet(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic modelReset();
        mPhase     = PH_IDLE;
        mPrev      = '0;
        mSeenClock = 0;
        mPend      = '0;
        mAddr      = '0;
        mId        = 0;
        for (int i = 0; i < 8; i++) mVec[i] = 32'h100 + 32'h10 * i;
    endtask

    task automatic modelStep();
        bit [7:0] rose;
        int       pick;
        rose = mSeenClock ? (i_src & ~mPrev) : 8'h00;
        pick = -1;
        if (mPhase == PH_IDLE || (mPhase == PH_SERVICE && i_reti))
            pick = lowestSet(mPend & i_en);
        if (mPhase == PH_ISSUE)                        mPhase = PH_SERVICE;
        else if (pick >= 0)                            mPhase = PH_ISSUE;
        else if (mPhase == PH_SERVICE && i_reti)       mPhase = PH_IDLE;
        if (pick >= 0) begin
            mAddr       = mVec[pick];
            mId         = pick;
            mPend[pick] = 1'b0;
        end
        mPend = mPend | rose;
        if (i_vec_we) mVec[i_vec_idx] = i_vec_data;
        mPrev      = i_src;
        mSeenClock = 1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll(input string ctx);
        checkOutput({ctx, ".irq"},     32'(o_IRQ),       32'(mPhase == PH_ISSUE));
        checkOutput({ctx, ".busy"},    32'(o_busy),      32'(mPhase != PH_IDLE));
        checkOutput({ctx, ".addr"},    o_ISR_addr,       mAddr);
        checkOutput({ctx, ".id"},      32'(o_active_id), 32'(mId));
        checkOutput({ctx, ".pending"}, 32'(o_pending),   32'(mPend));
    endtask

    // Called at a negedge: drives inputs, clocks once, advances the model and compares
    task automatic applyStimulus(input logic [7:0] src, input logic [7:0] en, input logic reti,
                                 input logic we, input logic [2:0] idx, input logic [31:0] data,
                                 input string ctx);
        i_src      = src;
        i_en       = en;
        i_reti     = reti;
        i_vec_we   = we;
        i_vec_idx  = idx;
        i_vec_data = data;
        @(posedge i_clk);
        modelStep();
        #1;
        compareAll(ctx);
        @(negedge i_clk);
    endtask

    task automatic step(input logic [7:0] src, input logic reti, input string ctx);
        applyStimulus(src, 8'hFF, reti, 1'b0, 3'd0, 32'h0, ctx);
    endtask

    // Asynchronous reset raised between clock edges; outputs must clear before any edge
    task automatic resetPulse(input string ctx);
        #2 i_rst = 1'b1;
        #1;
        modelReset();
        checkOutput({ctx, ".irq"},     32'(o_IRQ),      32'h0);
        checkOutput({ctx, ".busy"},    32'(o_busy),     32'h0);
        checkOutput({ctx, ".addr"},    o_ISR_addr,      32'h0);
        checkOutput({ctx, ".id"},      32'(o_active_id), 32'h0);
        checkOutput({ctx, ".pending"}, 32'(o_pending),  32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        logic [7:0] rSrc;
        i_rst = 1'b1; i_src = '0; i_en = 8'hFF; i_reti = 0;
        i_vec_we = 0; i_vec_idx = '0; i_vec_data = '0;
        modelReset();
        #1;
        compareAll("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        // Single source with default vector
        step(8'h00, 0, "single.arm");
        step(8'h04, 0, "single.edge");
        checkOutput("single.pend", 32'(o_pending), 32'h04);
        step(8'h04, 0, "single.issue");
        checkOutput("single.irqhi", 32'(o_IRQ), 32'h1);
        checkOutput("single.addr120", o_ISR_addr, 32'h0000_0120);
        checkOutput("single.id2", 32'(o_active_id), 32'd2);
        step(8'h04, 0, "single.svc");
        checkOutput("single.busy", 32'(o_busy), 32'h1);
        step(8'h04, 1, "single.reti");
        checkOutput("single.idle", 32'(o_busy), 32'h0);

        // Priority and tail-chain
        step(8'h00, 0, "prio.low");
        step(8'h22, 0, "prio.edge");
        step(8'h22, 0, "prio.issue1");
        checkOutput("prio.id1", 32'(o_active_id), 32'd1);
        checkOutput("prio.addr110", o_ISR_addr, 32'h0000_0110);
        step(8'h22, 0, "prio.svc");
        step(8'h22, 1, "prio.chain");
        checkOutput("chain.irq", 32'(o_IRQ), 32'h1);
        checkOutput("chain.id5", 32'(o_active_id), 32'd5);
        checkOutput("chain.addr150", o_ISR_addr, 32'h0000_0150);
        step(8'h22, 0, "chain.svc");
        step(8'h00, 1, "chain.reti");

        // Masked source waits until enabled
        applyStimulus(8'h10, 8'hEF, 0, 0, 3'd0, 32'h0, "mask.edge");
        applyStimulus(8'h10, 8'hEF, 0, 0, 3'd0, 32'h0, "mask.hold");
        checkOutput("mask.pend10", 32'(o_pending), 32'h10);
        checkOutput("mask.noirq", 32'(o_IRQ), 32'h0);
        step(8'h10, 0, "mask.enable");
        checkOutput("mask.id4", 32'(o_active_id), 32'd4);
        step(8'h00, 0, "mask.svc");
        step(8'h00, 1, "mask.reti");

        // Stray reti while idle
        step(8'h00, 1, "stray");
        checkOutput("stray.noirq", 32'(o_IRQ), 32'h0);

        // Vector writes
        applyStimulus(8'h00, 8'hFF, 0, 1, 3'd0, 32'hDEAD_0000, "vec.write");
        step(8'h01, 0, "vec.edge");
        step(8'h01, 0, "vec.issue");
        checkOutput("vec.addrDead", o_ISR_addr, 32'hDEAD_0000);
        applyStimulus(8'h01, 8'hFF, 0, 1, 3'd0, 32'hBEEF_0000, "vec.rewrite");
        checkOutput("vec.held", o_ISR_addr, 32'hDEAD_0000);
        step(8'h00, 1, "vec.reti");
        step(8'h01, 0, "vec.edge2");
        applyStimulus(8'h01, 8'hFF, 0, 1, 3'd0, 32'hCAFE_0000, "vec.sameCycle");
        checkOutput("vec.oldValue", o_ISR_addr, 32'hBEEF_0000);
        step(8'h00, 0, "vec.svc");
        step(8'h00, 1, "vec.reti2");

        // Reset during SERVICE with other sources pending
        step(8'h0D, 0, "rstsvc.edge");
        step(8'h0D, 0, "rstsvc.issue");
        step(8'h0D, 0, "rstsvc.svc");
        checkOutput("rstsvc.pend0C", 32'(o_pending), 32'h0C);
        resetPulse("rstsvc");
        step(8'h00, 0, "rstsvc.arm");
        step(8'h01, 0, "rstsvc.edge0");
        step(8'h01, 0, "rstsvc.issue0");
        checkOutput("rstsvc.vec0", o_ISR_addr, 32'h0000_0100);
        step(8'h00, 0, "rstsvc.svc0");

        // Reset during ISSUE, with sources held high across release
        step(8'h00, 1, "rstiss.reti");
        step(8'h02, 0, "rstiss.edge");
        step(8'h02, 0, "rstiss.issue");
        i_src = 8'hFF;
        resetPulse("rstiss");
        step(8'hFF, 0, "rel.high1");
        step(8'hFF, 0, "rel.high2");
        checkOutput("rel.noEdge", 32'(o_pending), 32'h00);
        step(8'h00, 0, "rel.low");
        step(8'hFF, 0, "rel.rise");

        // Randomized traffic
        rSrc = 8'hFF;
        for (int n = 0; n < 600; n++) begin
            rSrc = rSrc ^ 8'($urandom & $urandom);
            applyStimulus(rSrc, ~8'($urandom & $urandom & $urandom),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                          3'($urandom_range(0, 7)), $urandom, "rand");
            if (n % 150 == 149) resetPulse("rand.rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vic_irq_arbiter.md
VIC_IRQ_ARBITER -- requirements
Module: vic_irq_arbiter

Interface
REQ-001 Parameter NUM_IRQ, default 8: number of interrupt sources, fixed at 8 for this block; index 0..7.
REQ-002 Parameter VEC_BASE, default 32'h0000_0100: reset value of vector entry 0.
REQ-003 Parameter VEC_STRIDE, default 32'h0000_0010: reset spacing between consecutive vector entries.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_src  input  8  interrupt request lines, synchronous to i_clk, rising-edge triggered.
REQ-007 i_en  input  8  per-source enable mask; 1 = source may be selected.
REQ-008 i_reti  input  1  return-from-interrupt indication from core, sampled on i_clk.
REQ-009 i_vec_we  input  1  vector table write strobe.
REQ-010 i_vec_idx  input  3  vector table write index.
REQ-011 i_vec_data  input  32  vector table write data.
REQ-012 o_IRQ  output  1  one-cycle request pulse to downstream interrupt controller.
REQ-013 o_ISR_addr  output  32  ISR address of selected source; valid while o_IRQ high, held until next issue.
REQ-014 o_active_id  output  3  index of source currently issued/in service.
REQ-015 o_busy  output  1  high in ISSUE and SERVICE states.
REQ-016 o_pending  output  8  current pending register.

Function
REQ-017 Block SHALL register i_src each cycle; edge detected on bit k when i_src[k]=1 and prior sample=0.
REQ-018 Detected edge SHALL set pending[k] at that clock edge, regardless of i_en[k] and FSM state.
REQ-019 Selection SHALL be fixed priority over (pending & i_en), lowest index highest priority.
REQ-020 FSM states SHALL be IDLE, ISSUE, SERVICE.
REQ-021 IDLE: if (pending & i_en) nonzero, go ISSUE at next edge, latching winner into o_active_id, vec[winner] into o_ISR_addr, and clearing pending[winner] at the same edge.
REQ-022 ISSUE: o_IRQ SHALL be 1 for exactly this one cycle; unconditional transition to SERVICE.
REQ-023 SERVICE: o_IRQ 0; i_reti=1 with (pending & i_en) nonzero SHALL go directly to ISSUE (tail-chain) with same latch/clear actions as REQ-021; i_reti=1 with none eligible SHALL go IDLE; otherwise remain.
REQ-024 i_reti in IDLE or ISSUE SHALL be ignored.
REQ-025 No nesting: new edges during ISSUE/SERVICE only set pending; no preemption.
REQ-026 Edge on bit k in the same cycle pending[k] is cleared by selection SHALL leave pending[k]=1 (set wins).
REQ-027 Pending bit with i_en=0 SHALL persist, unselected, until enabled.
REQ-028 Second edge on an already-pending source SHALL be merged (no count).
REQ-029 i_vec_we=1 SHALL write i_vec_data to vec[i_vec_idx] at the clock edge; latched o_ISR_addr SHALL NOT change by a write to the in-service entry.
REQ-030 Write and selection of the same index in one cycle: o_ISR_addr SHALL take the old vector value; new value applies to later issues.
REQ-031 Latency: edge sampled at E0 with FSM IDLE -> o_IRQ high between E1 and E2.

Reset
REQ-032 On i_rst=1, immediately: state IDLE, o_IRQ=0, o_ISR_addr=0, o_active_id=0, o_busy=0, pending=0, o_pending=0, source sample register=0.
REQ-033 Reset SHALL load vec[k]=VEC_BASE+k*VEC_STRIDE (entry 3 = 32'h0000_0130).
REQ-034 Reset asserted mid-ISSUE or mid-SERVICE SHALL abort: o_IRQ drops without waiting for clock; no pending retained.
REQ-035 After reset release, sources already high SHALL NOT generate an edge until they return low then high.

Verification
REQ-036 Single: i_en=8'hFF, i_src[2] 0->1 at E0 -> o_IRQ high E1..E2, o_ISR_addr=32'h0000_0120, o_active_id=2, o_busy=1 until i_reti.
REQ-037 Priority/tail-chain: i_src[5] and i_src[1] rise same edge -> issue id 1 (addr 32'h0000_0110); i_reti pulse -> next cycle o_IRQ with id 5 (32'h0000_0150), no IDLE cycle between.
REQ-038 Mask: i_en[4]=0, i_src[4] rises -> o_pending=8'h10, no o_IRQ; set i_en[4]=1 -> issue id 4 next edge.
REQ-039 Vector write: write 32'hDEAD_0000 to idx 0, then i_src[0] rises -> o_ISR_addr=32'hDEAD_0000; rewrite during SERVICE -> o_ISR_addr unchanged.
REQ-040 Reset mid-SERVICE with pending=8'h0C -> all outputs 0, o_pending=0, vec[0]=32'h0000_0100 restored.
REQ-041 Stray i_reti in IDLE -> no state change, no o_IRQ.
